mult_div_unit: RTL and testbench
================================

# mult_div_unit

Iterative multi-cycle multiply/divide unit owning the architectural HI/LO registers. Sits in the EX stage beside the ALU: it takes the same forwarded operands and ALUOP control code, and its oHI/oLO outputs feed the ALU result mux for OPMFHI/OPMFLO. It replaces single-cycle `*`, `/` and `%` with a 33-cycle shift-add and restoring-divide datapath, and asserts oBusy so the hazard unit can stall mfhi/mflo and further mult/div.

## Interface
- No parameters. Width is fixed at 32; iteration count is fixed at 32.
- iCLK  in  1  clock
- iRST  in  1  reset, synchronous, active-high
- iEnable  in  1  EX-stage instruction valid (not bubble, not flushed)
- iControlSignal  in  5  ALUOP code; only OPMULT, OPMULTU, OPDIV, OPDIVU, OPMTHI, OPMTLO are acted on
- iA  in  32  rs operand (dividend, multiplicand, MTHI/MTLO data)
- iB  in  32  rt operand (divisor, multiplier)
- oBusy  out  1  operation in progress
- oDone  out  1  one-cycle pulse: HI/LO just updated by mult/div
- oHI  out  32  HI register
- oLO  out  32  LO register

## Operation
- States: IDLE, CALC, FIX.
- Priority, highest first: iRST, then MTHI/MTLO, then start.
- Start: iEnable, one of the four mult/div codes, and state IDLE.
  - Latches |iA|, |iB| (raw values for unsigned ops), op kind, and result signs.
  - Clears the 6-bit counter and goes to CALC.
- CALC, one bit per cycle for 32 cycles:
  - Multiply: 64-bit shift-add, LSB first.
  - Divide: restoring; 33-bit partial remainder; quotient shifted in MSB first.
- FIX:
  - Signed multiply: product negated if the operand signs differ.
  - Signed divide: quotient negated if the signs differ; remainder takes the dividend's sign.
  - HI/LO written, oDone asserted, then back to IDLE.
- Start while busy is ignored. The pipeline must stall, so this is a protocol error; the block is still required to ignore it.
- MTHI/MTLO (with iEnable) write iA to HI/LO at the next edge in any state.
  - If busy, the write aborts the operation: state goes to IDLE, no oDone, and the written register keeps iA.
  - Only one of MTHI/MTLO is decoded per cycle.
- Divide by zero, signed or unsigned: LO = 0xFFFFFFFF, HI = iA as originally presented. Full 33-cycle latency is kept.
- DIV of 0x80000000 by 0xFFFFFFFF: LO = 0x80000000, HI = 0 (natural wrap, no trap).
- Sign handling: magnitude of 0x80000000 is 2^31, which fits unsigned 32-bit. Negation is two's complement at 32 bits (64 bits for the product).

## Timing
- Reset values: state IDLE, oHI = 0, oLO = 0, oBusy = 0, oDone = 0, counter 0.
- Reset mid-operation clears everything above at the next edge.
- Start accepted at edge t:
  - oBusy = 1 after edge t.
  - CALC spans edges t+1 … t+32.
  - FIX write happens at edge t+33.
- After edge t+33: oHI/oLO hold the result, oBusy = 0, oDone = 1 for exactly one cycle.
- A new start is accepted at edge t+33 or later (same cycle that oDone is high).
- oHI/oLO are stable (previous values) throughout CALC; no intermediate values are visible.
- oBusy is registered; it does not depend combinationally on iControlSignal.

## Structure
- Shared package/include: existing ALUOP constants (OPMULT, OPMULTU, OPDIV, OPDIVU, OPMTHI, OPMTLO). No new codes.
- Local: state encoding (2-bit), counter terminal value 31.
- Single module, no sub-module. Multiply and divide share the 64-bit working register {rem/hi, acc/lo} and the 33-bit adder/subtractor.

## Test plan
- MULT 7 × 0xFFFFFFFD (−3) -> after 33 cycles HI = 0xFFFFFFFF, LO = 0xFFFFFFEB; oDone high exactly one cycle; oBusy low at the same time.
- MULTU 0xFFFFFFFF × 0xFFFFFFFF -> HI = 0xFFFFFFFE, LO = 0x00000001.
- DIV 0xFFFFFFF9 (−7) / 2 -> LO = 0xFFFFFFFD, HI = 0xFFFFFFFF; DIVU 0x64 / 0 -> LO = 0xFFFFFFFF, HI = 0x00000064.
- DIV 0x80000000 / 0xFFFFFFFF -> LO = 0x80000000, HI = 0; DIVU 0xFFFFFFFF / 0x10 -> LO = 0x0FFFFFFF, HI = 0xF.
- Start MULT, re-assert MULT with new operands at cycle 5 -> ignored, original result delivered at cycle 33; MTLO 0x1234 at cycle 10 of a DIV -> LO = 0x1234 next cycle, oBusy drops, no oDone, HI unchanged.
- iRST at cycle 10 of a MULTU -> next cycle HI = LO = 0, oBusy = 0, no oDone; new MULT started immediately completes normally.

Source files
------------

// File: rtl/mult_div_unit_pkg.sv
// mult_div_unit_pkg: ALUOP codes shared with the ALU plus local constants
// for the iterative multiply/divide unit.
package mult_div_unit_pkg;
    localparam logic [4:0] OPMULT  = 5'd16;
    localparam logic [4:0] OPMULTU = 5'd17;
    localparam logic [4:0] OPDIV   = 5'd18;
    localparam logic [4:0] OPDIVU  = 5'd19;
    localparam logic [4:0] OPMTHI  = 5'd20;
    localparam logic [4:0] OPMTLO  = 5'd21;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_CALC = 2'd1;
    localparam logic [1:0] ST_FIX  = 2'd2;

    localparam logic [5:0] CNT_LAST = 6'd31;

    function automatic logic [31:0] abs32(input logic [31:0] v, input logic sgn);
        return (sgn && v[31]) ? ~v + 32'd1 : v;
    endfunction
endpackage

// File: rtl/mult_div_unit.sv
// mult_div_unit: 33-cycle shift-add multiplier / restoring divider owning HI/LO.
// Multiply and divide share one 64-bit working register and one 33-bit adder.
module mult_div_unit
    import mult_div_unit_pkg::*;
(
    input  logic        iCLK,
    input  logic        iRST,
    input  logic        iEnable,
    input  logic [4:0]  iControlSignal,
    input  logic [31:0] iA,
    input  logic [31:0] iB,
    output logic        oBusy,
    output logic        oDone,
    output logic [31:0] oHI,
    output logic [31:0] oLO
);
    logic [1:0]  state_q, state_d;
    logic [5:0]  cnt_q, cnt_d;
    logic [63:0] work_q, work_d;
    logic [31:0] opnd_q, opnd_d;
    logic        is_div_q, is_div_d;
    logic        neg_lo_q, neg_lo_d;
    logic        neg_hi_q, neg_hi_d;
    logic [31:0] hi_q, hi_d;
    logic [31:0] lo_q, lo_d;
    logic        done_q, done_d;

    logic        mt_hi, mt_lo, op_div, op_signed, start;
    logic [32:0] op_a;
    logic [33:0] sum;
    logic [63:0] prod;
    logic [31:0] quo, rem, abs_a, abs_b;

    assign mt_hi     = iEnable && iControlSignal == OPMTHI;
    assign mt_lo     = iEnable && iControlSignal == OPMTLO;
    assign op_div    = iControlSignal == OPDIV || iControlSignal == OPDIVU;
    assign op_signed = iControlSignal == OPMULT || iControlSignal == OPDIV;
    assign start     = iEnable && state_q == ST_IDLE &&
                       (op_div || iControlSignal == OPMULT || iControlSignal == OPMULTU);
    assign abs_a     = abs32(iA, op_signed);
    assign abs_b     = abs32(iB, op_signed);

    always_comb begin
        // Divide: 33-bit partial remainder is {hi, next dividend bit}; multiply: {carry, hi}.
        op_a     = is_div_q ? {work_q[63:32], work_q[31]} : {1'b0, work_q[63:32]};
        sum      = is_div_q ? {1'b0, op_a} - {2'b0, opnd_q} : {1'b0, op_a} + {2'b0, opnd_q};
        prod     = neg_lo_q ? ~work_q + 64'd1 : work_q;
        quo      = neg_lo_q ? ~work_q[31:0] + 32'd1 : work_q[31:0];
        rem      = neg_hi_q ? ~work_q[63:32] + 32'd1 : work_q[63:32];
        state_d  = state_q;
        cnt_d    = cnt_q;
        work_d   = work_q;
        opnd_d   = opnd_q;
        is_div_d = is_div_q;
        neg_lo_d = neg_lo_q;
        neg_hi_d = neg_hi_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        done_d   = 1'b0;
        if (mt_hi || mt_lo) begin
            hi_d    = mt_hi ? iA : hi_q;
            lo_d    = mt_lo ? iA : lo_q;
            state_d = ST_IDLE;
        end else if (start) begin
            state_d  = ST_CALC;
            cnt_d    = 6'd0;
            is_div_d = op_div;
            work_d   = {32'd0, op_div ? abs_a : abs_b};
            opnd_d   = op_div ? abs_b : abs_a;
            // Divide by zero keeps the all-ones quotient and the raw dividend as remainder.
            neg_lo_d = op_signed && (iA[31] ^ iB[31]) && !(op_div && iB == 32'd0);
            neg_hi_d = op_signed && op_div && iA[31];
        end else if (state_q == ST_CALC) begin
            work_d = is_div_q
                ? {sum[33] ? op_a[31:0] : sum[31:0], work_q[30:0], ~sum[33]}
                : {work_q[0] ? sum[32:0] : op_a, work_q[31:1]};
            cnt_d   = cnt_q + 6'd1;
            state_d = cnt_q == CNT_LAST ? ST_FIX : ST_CALC;
        end else if (state_q == ST_FIX) begin
            hi_d    = is_div_q ? rem : prod[63:32];
            lo_d    = is_div_q ? quo : prod[31:0];
            done_d  = 1'b1;
            state_d = ST_IDLE;
        end
    end

    always_ff @(posedge iCLK) begin
        if (iRST) begin
            state_q  <= ST_IDLE;
            cnt_q    <= 6'd0;
            work_q   <= 64'd0;
            opnd_q   <= 32'd0;
            is_div_q <= 1'b0;
            neg_lo_q <= 1'b0;
            neg_hi_q <= 1'b0;
            hi_q     <= 32'd0;
            lo_q     <= 32'd0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            work_q   <= work_d;
            opnd_q   <= opnd_d;
            is_div_q <= is_div_d;
            neg_lo_q <= neg_lo_d;
            neg_hi_q <= neg_hi_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            done_q   <= done_d;
        end
    end

    assign oBusy = state_q != ST_IDLE;
    assign oDone = done_q;
    assign oHI   = hi_q;
    assign oLO   = lo_q;
endmodule

// File: tb/tb_mult_div_unit.sv
// tb_mult_div_unit: directed tests of the iterative multiply/divide unit.
module tb_mult_div_unit;
    import mult_div_unit_pkg::*;

    logic        iCLK = 1'b0;
    logic        iRST = 1'b1;
    logic        iEnable = 1'b0;
    logic [4:0]  iControlSignal = 5'd0;
    logic [31:0] iA = 32'd0;
    logic [31:0] iB = 32'd0;
    logic        oBusy, oDone;
    logic [31:0] oHI, oLO;

    int n_checks = 0;
    int n_fail = 0;

    mult_div_unit dut (
        .iCLK(iCLK), .iRST(iRST), .iEnable(iEnable), .iControlSignal(iControlSignal),
        .iA(iA), .iB(iB), .oBusy(oBusy), .oDone(oDone), .oHI(oHI), .oLO(oLO)
    );

    always #5 iCLK = ~iCLK;

    // Called at a negedge; presents one instruction for exactly one rising edge.
    task automatic issue(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
        iEnable = 1'b1; iControlSignal = op; iA = a; iB = b;
        @(negedge iCLK);
        iEnable = 1'b0; iControlSignal = 5'd0;
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) @(negedge iCLK);
    endtask

    // Issues an op, checks mid-CALC and completion timing and the result.
    task automatic run_op(input string name, input logic [4:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp_hi, input logic [31:0] exp_lo);
        logic [31:0] prev_hi, prev_lo;
        prev_hi = oHI; prev_lo = oLO;
        issue(op, a, b);
        wait_cycles(16);
        n_checks++;
        if (oHI !== prev_hi || oLO !== prev_lo) begin
            n_fail++; $display("FAIL %s mid_calc_hilo: got %h_%h expected %h_%h", name, oHI, oLO, prev_hi, prev_lo);
        end
        wait_cycles(16);
        n_checks++;
        if (oBusy !== 1'b1 || oDone !== 1'b0) begin
            n_fail++; $display("FAIL %s cycle32 busy/done: got %b/%b expected 1/0", name, oBusy, oDone);
        end
        wait_cycles(1);
        n_checks++;
        if (oBusy !== 1'b0 || oDone !== 1'b1) begin
            n_fail++; $display("FAIL %s cycle33 busy/done: got %b/%b expected 0/1", name, oBusy, oDone);
        end
        n_checks++;
        if (oHI !== exp_hi || oLO !== exp_lo) begin
            n_fail++; $display("FAIL %s result: got %h_%h expected %h_%h", name, oHI, oLO, exp_hi, exp_lo);
        end
    endtask

    task automatic test_reset();
        iRST = 1'b1;
        wait_cycles(2);
        iRST = 1'b0;
        n_checks++;
        if (oHI !== 32'd0 || oLO !== 32'd0 || oBusy !== 1'b0 || oDone !== 1'b0) begin
            n_fail++; $display("FAIL reset: got hi=%h lo=%h busy=%b done=%b expected all zero", oHI, oLO, oBusy, oDone);
        end
    endtask

    task automatic test_mult();
        run_op("mult_7x-3", OPMULT, 32'd7, 32'hFFFFFFFD, 32'hFFFFFFFF, 32'hFFFFFFEB);
        wait_cycles(1);
        n_checks++;
        if (oDone !== 1'b0) begin
            n_fail++; $display("FAIL mult_done_pulse: got %b expected 0", oDone);
        end
        run_op("multu_max", OPMULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001);
        run_op("mult_max_neg", OPMULT, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000);
    endtask

    task automatic test_div();
        run_op("div_-7/2", OPDIV, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 32'hFFFFFFFD);
        run_op("divu_by0", OPDIVU, 32'h64, 32'd0, 32'h00000064, 32'hFFFFFFFF);
        run_op("div_neg_by0", OPDIV, 32'hFFFFFFF9, 32'd0, 32'hFFFFFFF9, 32'hFFFFFFFF);
        run_op("div_ovf", OPDIV, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000);
        run_op("divu_big", OPDIVU, 32'hFFFFFFFF, 32'h10, 32'h0000000F, 32'h0FFFFFFF);
        run_op("div_7/-2", OPDIV, 32'd7, 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD);
    endtask

    task automatic test_start_while_busy();
        issue(OPMULT, 32'd3, 32'd5);
        wait_cycles(4);
        issue(OPMULT, 32'd100, 32'd100);
        wait_cycles(27);
        n_checks++;
        if (oBusy !== 1'b1 || oDone !== 1'b0) begin
            n_fail++; $display("FAIL ignore_start cycle32: got busy=%b done=%b expected 1/0", oBusy, oDone);
        end
        wait_cycles(1);
        n_checks++;
        if (oDone !== 1'b1 || oHI !== 32'd0 || oLO !== 32'd15) begin
            n_fail++; $display("FAIL ignore_start result: got done=%b %h_%h expected 1 00000000_0000000f", oDone, oHI, oLO);
        end
    endtask

    task automatic test_back_to_back();
        // Issued in the cycle oDone is high from the previous test.
        run_op("b2b_multu", OPMULTU, 32'h00010000, 32'h00010000, 32'h00000001, 32'h00000000);
    endtask

    task automatic test_mt_abort();
        int pulses;
        issue(OPMTHI, 32'h0000ABCD, 32'd0);
        n_checks++;
        if (oHI !== 32'h0000ABCD || oLO !== 32'd0 || oBusy !== 1'b0) begin
            n_fail++; $display("FAIL mthi_idle: got %h_%h busy=%b expected 0000abcd_00000000 busy=0", oHI, oLO, oBusy);
        end
        issue(OPDIV, 32'd100, 32'd7);
        wait_cycles(9);
        issue(OPMTLO, 32'h00001234, 32'd0);
        n_checks++;
        if (oLO !== 32'h00001234 || oHI !== 32'h0000ABCD || oBusy !== 1'b0 || oDone !== 1'b0) begin
            n_fail++; $display("FAIL mtlo_abort: got %h_%h busy=%b done=%b expected 0000abcd_00001234 0 0", oHI, oLO, oBusy, oDone);
        end
        pulses = 0;
        for (int i = 0; i < 30; i++) begin
            @(negedge iCLK);
            if (oDone === 1'b1 || oBusy === 1'b1) pulses++;
        end
        n_checks++;
        if (pulses !== 0 || oLO !== 32'h00001234 || oHI !== 32'h0000ABCD) begin
            n_fail++; $display("FAIL mtlo_abort_after: got activity=%0d %h_%h expected 0 0000abcd_00001234", pulses, oHI, oLO);
        end
    endtask

    task automatic test_reset_mid();
        issue(OPMULTU, 32'h0000FFFF, 32'h0000FFFF);
        wait_cycles(9);
        iRST = 1'b1;
        @(negedge iCLK);
        iRST = 1'b0;
        n_checks++;
        if (oHI !== 32'd0 || oLO !== 32'd0 || oBusy !== 1'b0 || oDone !== 1'b0) begin
            n_fail++; $display("FAIL reset_mid: got hi=%h lo=%h busy=%b done=%b expected all zero", oHI, oLO, oBusy, oDone);
        end
        run_op("mult_after_rst", OPMULT, 32'hFFFFFFFE, 32'h10, 32'hFFFFFFFF, 32'hFFFFFFE0);
    endtask

    initial begin
        @(negedge iCLK);
        test_reset();
        test_mult();
        test_div();
        wait_cycles(1);
        test_start_while_busy();
        test_back_to_back();
        test_mt_abort();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
